lfsr_share_ctrl: RTL and testbench



---
 rtl/lfsr_share_ctrl.sv | 113 +++++++++++
 tb/tb_lfsr_share_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_share_ctrl.sv
// lfsr_share_ctrl: one 10-bit XNOR LFSR shared by N requesters through a
// round-robin arbiter. A granted draw steps the LFSR STEPS times, then
// delivers the new value with a one-cycle valid pulse.
// Optional macro LFSR_SEED_EN adds seed_load/seed ports for reseeding in IDLE.
module lfsr_share_ctrl #(
  parameter int N     = 4,
  parameter int STEPS = 4
) (
  input  logic         clk,
  input  logic         reset,
`ifdef LFSR_SEED_EN
  input  logic         seed_load,
  input  logic [9:0]   seed,
`endif
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         valid,
  output logic [9:0]   data,
  output logic         busy
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] NW = (IW+1)'(N);

  typedef enum logic [1:0] {IDLE, STEP, DELIVER} state_t;

  state_t        state, state_nxt;
  logic [9:0]    q, q_step;
  logic [3:0]    cnt;
  logic [IW-1:0] ptr, gidx, arb_idx;
  logic          arb_hit;
  logic [IW:0]   scan;

  // One XNOR shift; all-ones is a fixed point and unreachable from zero.
  assign q_step = {~(q[3] ^ q[0]), q[9:1]};

  // Round-robin pick: first requester at or after ptr, wrapping at N.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    scan    = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr} + (IW+1)'(k);
      if (scan >= NW) scan = scan - NW;
      if (!arb_hit && req[scan[IW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = scan[IW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: arbitrate, count down the steps, deliver for one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_hit) state_nxt = STEP;
      STEP:    if (cnt == 4'd0) state_nxt = DELIVER;
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; req is only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= 10'h000;
      cnt   <= 4'd0;
      ptr   <= '0;
      gidx  <= '0;
      gnt   <= '0;
      valid <= 1'b0;
      data  <= 10'h000;
      busy  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
`ifdef LFSR_SEED_EN
          // Never seed into the lock-up state.
          if (seed_load) q <= (seed == 10'h3FF) ? 10'h000 : seed;
`endif
          if (arb_hit) begin
            gnt  <= {{(N-1){1'b0}}, 1'b1} << arb_idx;
            gidx <= arb_idx;
            cnt  <= 4'(STEPS - 1);
            busy <= 1'b1;
          end
        end
        STEP: begin
          q   <= q_step;
          cnt <= cnt - 4'd1;
          // Last step: publish the post-step value together with valid.
          if (cnt == 4'd0) begin
            data  <= q_step;
            valid <= 1'b1;
          end
        end
        DELIVER: begin
          gnt  <= '0;
          busy <= 1'b0;
          ptr  <= (gidx == IW'(N - 1)) ? '0 : gidx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// tb_lfsr_share_ctrl: randomized draws checked against a transaction-level
// model (round-robin pick by modular scan, LFSR advanced by step count).
module tb_lfsr_share_ctrl;
  localparam int N     = 4;
  localparam int STEPS = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         seed_load;
  logic [9:0]   seed;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         valid;
  logic [9:0]   data;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [9:0] exp_q    = 10'h000;
  logic [9:0] exp_data = 10'h000;
  int         exp_ptr  = 0;
  int         last_idx = -1;

  always #5 clk = ~clk;

  lfsr_share_ctrl #(.N(N), .STEPS(STEPS)) dut (
    .clk(clk),
    .reset(reset),
`ifdef LFSR_SEED_EN
    .seed_load(seed_load),
    .seed(seed),
`endif
    .req(req),
    .gnt(gnt),
    .valid(valid),
    .data(data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] lfsr_adv(input logic [9:0] v, input int n);
    logic [9:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {~(r[3] ^ r[0]), r[9:1]};
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    exp_q    = 10'h000;
    exp_data = 10'h000;
    exp_ptr  = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_gnt"},   gnt,   '0);
    chk({tag, "_busy"},  busy,  1'b0);
    chk({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_data"},  data,  exp_data);
  endtask

  // Entered #1 after an edge with the DUT in IDLE; leaves it the same way.
  // mode: 0 hold req, 1 drop req after grant, 2 scramble req during draw.
  // abort_at: draw cycle (1..STEPS+1) in which reset is raised, 0 = none.
  task automatic do_draw(input logic [N-1:0] r, input int mode, input int abort_at);
    int idx;
    logic [N-1:0] oh;
    req = r;
    idx = pick(r, exp_ptr);
    if (seed_load) exp_q = (seed == 10'h3FF) ? 10'h000 : seed;
    @(posedge clk); #1;
    seed_load = 1'b0;
    if (idx < 0) begin
      last_idx = -1;
      check_idle("nogrant");
      return;
    end
    last_idx = idx;
    oh       = '0;
    oh[idx]  = 1'b1;
    exp_q    = lfsr_adv(exp_q, STEPS);
    exp_ptr  = (idx + 1) % N;
    for (int c = 1; c <= STEPS + 1; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      chk("draw_gnt",  gnt,  oh);
      chk("draw_busy", busy, 1'b1);
      chk("draw_valid", valid, (c == STEPS + 1));
      if (c == STEPS + 1) exp_data = exp_q;
      chk("draw_data", data, exp_data);
      if (c == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        seed_load = 1'b0;
        model_reset();
        check_idle("abort");
        return;
      end
      if (mode == 1) req = '0;
      else if (mode == 2) req = N'($urandom);
`ifdef LFSR_SEED_EN
      seed_load = 1'($urandom);
      seed      = 10'($urandom);
`endif
      if (c == STEPS + 1) seed_load = 1'b0;
    end
    @(posedge clk); #1;
    check_idle("after");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    seed_load = 1'b0;
    seed      = 10'h000;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;
    model_reset();

    // single requester, two consecutive draws from the reset sequence
    do_draw(4'b0001, 0, 0);
    chk("first_draw", data, 10'h3C0);
    do_draw(4'b0001, 0, 0);
    chk("second_draw", data, 10'h1FC);

    // all requesting: grants rotate 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_draw(4'b1111, 0, 0);
      chk("rotate_idx", last_idx, i % N);
    end

    // lone requester 2 must be found again after the pointer moves to 3
    do_reset();
    do_draw(4'b0100, 0, 0);
    chk("lone_idx_a", last_idx, 2);
    do_draw(4'b0100, 0, 0);
    chk("lone_idx_b", last_idx, 2);

    // reset in the second STEP cycle, then a fresh draw from zero
    do_draw(4'b0010, 0, 2);
    do_draw(4'b0010, 0, 0);
    chk("post_abort", data, 10'h3C0);

    // request dropped right after grant still delivers
    do_draw(4'b1000, 1, 0);
    do_draw(4'b0000, 0, 0);

`ifdef LFSR_SEED_EN
    // lock-up seed is replaced by zero
    seed_load = 1'b1;
    seed      = 10'h3FF;
    do_draw(4'b0000, 0, 0);
    do_draw(4'b0001, 0, 0);
    chk("seed_lockup", data, 10'h3C0);
    // seed together with a grant
    seed_load = 1'b1;
    seed      = 10'h155;
    do_draw(4'b0010, 2, 0);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [N-1:0] r;
      int mode, ab;
      r    = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      mode = $urandom_range(0, 2);
      ab   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, STEPS + 1) : 0;
`ifdef LFSR_SEED_EN
      seed_load = ($urandom_range(0, 4) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
`endif
      do_draw(r, mode, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
